heartbeat_rx: RTL and testbench
===============================

HEARTBEAT_RX -- requirements
Module: heartbeat_rx

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive correctly-incrementing bytes required before lock.
REQ-002 Parameter MISS_LIMIT, default 2: consecutive sequence mismatches while locked that force relock.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 signal_in  input  1  Manchester line from the heartbeat transmitter (same clk domain, 2 clocks per bit).
REQ-006 byte_out  output  8  last decoded counter byte.
REQ-007 byte_valid  output  1  one-cycle pulse when byte_out updates (LOCKED only).
REQ-008 locked  output  1  high in LOCKED state.
REQ-009 phase_err  output  1  one-cycle pulse on half-bit violation.
REQ-010 seq_err  output  1  one-cycle pulse on sequence mismatch while locked.
REQ-011 err_count  output  8  saturating count of phase_err plus seq_err pulses.

Function
REQ-012 Line encoding: each bit spans two clocks, first half = bit value, second half = inverted bit; bytes MSB first; each byte equals the previous byte + 1 mod 256.
REQ-013 signal_in is registered once (s_q) before any decoding.
REQ-014 A half-phase toggle pairs consecutive s_q samples as (first, second); a pair with first != second yields decoded bit = first.
REQ-015 A pair with first == second is a phase violation: pulse phase_err, hold the toggle for one extra cycle (one-clock slip), clear the decoded-bit counter, enter SEARCH.
REQ-016 Decoded bits shift left into a 16-bit window; new bit enters at [0].
REQ-017 States: SEARCH, VERIFY, LOCKED; SEARCH is the reset state.
REQ-018 SEARCH: after at least 16 decoded bits since the last violation/reset, on any bit where window[7:0] == window[15:8] + 1 mod 256, set last_byte = window[7:0], bit_cnt = 0, good_cnt = 1, go to VERIFY.
REQ-019 VERIFY: every 8th decoded bit compare new byte with last_byte + 1; match -> good_cnt++, last_byte = new byte; when good_cnt reaches LOCK_COUNT go to LOCKED and emit that byte; mismatch -> SEARCH.
REQ-020 LOCKED: every 8th decoded bit update byte_out and pulse byte_valid regardless of match; last_byte always updated to the received byte.
REQ-021 LOCKED mismatch: pulse seq_err, increment miss counter; miss counter reaching MISS_LIMIT -> SEARCH; any match clears miss counter.
REQ-022 LOCKED phase violation: SEARCH immediately; no byte_valid for the partial byte.
REQ-023 Wrap: 0xFF followed by 0x00 is a match in all states.
REQ-024 Latency: byte_valid is high exactly 2 clocks after the clock edge at which signal_in carries the second half of the byte's LSB (input register + output register).
REQ-025 err_count saturates at 255; a simultaneous phase_err and seq_err cannot occur (violation pre-empts byte completion).
REQ-026 locked is low in SEARCH and VERIFY, high in LOCKED, changes registered with the state.

Reset
REQ-027 rst high at a clock edge: state = SEARCH, byte_out = 0, byte_valid = 0, locked = 0, phase_err = 0, seq_err = 0, err_count = 0, window, counters and half-phase toggle = 0.
REQ-028 Reset mid-byte discards the partial byte; decoding restarts from the first sample after rst deasserts.

Structure
REQ-029 State encoding enum and default LOCK_COUNT/MISS_LIMIT constants live in the shared heartbeat package.
REQ-030 Half-bit pairing/phase-slip logic is a sub-module manchester_bit_dec (outputs bit, bit_strobe, violation); framing FSM stays in heartbeat_rx.

Verification
REQ-031 Heartbeat transmitter model at counter 0x10 -> locked within LOCK_COUNT+3 bytes; consecutive byte_out values increment by 1.
REQ-032 Start the transmitter one clock offset from the rx half-phase -> phase_err pulses at most until first bit change, then lock; err_count equals phase_err pulses.
REQ-033 While locked, replace byte 0x42 with 0x50 once -> one seq_err, byte_out 0x50 emitted, locked stays high, next byte 0x51 clears miss counter.
REQ-034 Counter wrap 0xFE,0xFF,0x00,0x01 while locked -> no seq_err, byte_valid every 16 clocks.
REQ-035 Force a half-bit (both halves 1) while locked -> phase_err, locked low next cycle, relock after resync.
REQ-036 Assert rst mid-byte while locked -> all outputs zero next cycle; relock with no spurious byte_valid.

Source files
------------

// File: rtl/heartbeat_rx_pkg.sv
// Shared definitions for the heartbeat receiver: framing state encoding,
// default lock/miss thresholds, widths and the counter-increment helper.
package heartbeat_rx_pkg;

    localparam int unsigned LOCK_COUNT_DEF = 4;
    localparam int unsigned MISS_LIMIT_DEF = 2;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WIN_W  = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NBIT_W = 5;

    // Framing state encoding
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Heartbeat counter successor; the 8-bit add wraps 0xFF to 0x00
    function automatic logic [BYTE_W-1:0] next_byte(input logic [BYTE_W-1:0] b);
        return b + BYTE_W'(1);
    endfunction

endpackage

// File: rtl/heartbeat_rx_bit_dec.sv
// Manchester half-bit pairing with one-clock phase slip.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   signal_in     : raw Manchester line (2 clocks per bit)
//   bit_c         : decoded bit value (valid with bit_strobe_c)
//   bit_strobe_c  : a well-formed half-bit pair completed this cycle
//   violation_c   : a pair with equal halves completed this cycle
module manchester_bit_dec (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic bit_c,
    output logic bit_strobe_c,
    output logic violation_c
);

    logic s_q;
    logic s_vld;
    logic half;
    logic first;

    // Input register, then alternate first/second half captures
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 1'b0;
            s_vld <= 1'b0;
            half  <= 1'b0;
            first <= 1'b0;
        end else begin
            s_q   <= signal_in;
            s_vld <= 1'b1;
            if (s_vld) begin
                if (!half) begin
                    first <= s_q;
                    half  <= 1'b1;
                end else if (first != s_q) begin
                    half  <= 1'b0;
                end
                // Equal halves: half stays set, so this sample (== first)
                // becomes the first half of the next pair -- a one-clock slip.
            end
        end
    end

    assign bit_c        = first;
    assign bit_strobe_c = half & (first != s_q);
    assign violation_c  = half & (first == s_q);

endmodule

// File: rtl/heartbeat_rx.sv
// Heartbeat receiver: decodes a Manchester line carrying an incrementing
// byte counter, searches for byte alignment, verifies and tracks lock.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   signal_in   : Manchester line, 2 clocks per bit, MSB first
//   byte_out    : last decoded counter byte
//   byte_valid  : one-cycle pulse when byte_out updates (locked only)
//   locked      : high while locked
//   phase_err   : one-cycle pulse on a half-bit violation
//   seq_err     : one-cycle pulse on a sequence mismatch while locked
//   err_count   : saturating count of phase_err and seq_err pulses
module heartbeat_rx
    import heartbeat_rx_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int unsigned MISS_LIMIT = MISS_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signal_in,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              locked,
    output logic              phase_err,
    output logic              seq_err,
    output logic [BYTE_W-1:0] err_count
);

    logic dec_bit_c;
    logic dec_strobe_c;
    logic dec_violation_c;

    manchester_bit_dec u_bit_dec (
        .clk          (clk),
        .rst          (rst),
        .signal_in    (signal_in),
        .bit_c        (dec_bit_c),
        .bit_strobe_c (dec_strobe_c),
        .violation_c  (dec_violation_c)
    );

    logic [1:0]        state,     state_nxt;
    logic [WIN_W-1:0]  win,       win_nxt;
    logic [NBIT_W-1:0] nbits,     nbits_nxt;
    logic [2:0]        bit_cnt,   bit_cnt_nxt;
    logic [CNT_W-1:0]  good_cnt,  good_nxt;
    logic [CNT_W-1:0]  miss_cnt,  miss_nxt;
    logic [BYTE_W-1:0] last_byte, last_nxt;
    logic [BYTE_W-1:0] byte_out_nxt;
    logic [BYTE_W-1:0] err_nxt;
    logic              byte_valid_nxt;
    logic              phase_err_nxt;
    logic              seq_err_nxt;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_done;
    logic              seq_match;

    // Next-state and output decode
    always_comb begin
        state_nxt      = state;
        win_nxt        = win;
        nbits_nxt      = nbits;
        bit_cnt_nxt    = bit_cnt;
        good_nxt       = good_cnt;
        miss_nxt       = miss_cnt;
        last_nxt       = last_byte;
        byte_out_nxt   = byte_out;
        byte_valid_nxt = 1'b0;
        phase_err_nxt  = 1'b0;
        seq_err_nxt    = 1'b0;
        err_nxt        = err_count;
        rx_byte        = '0;
        byte_done      = 1'b0;
        seq_match      = 1'b0;

        if (dec_violation_c) begin
            // A violation pre-empts any byte in progress
            phase_err_nxt = 1'b1;
            nbits_nxt     = '0;
            bit_cnt_nxt   = '0;
            state_nxt     = ST_SEARCH;
        end else if (dec_strobe_c) begin
            win_nxt     = {win[WIN_W-2:0], dec_bit_c};
            if (nbits != NBIT_W'(WIN_W)) begin
                nbits_nxt = nbits + NBIT_W'(1);
            end
            rx_byte     = win_nxt[BYTE_W-1:0];
            seq_match   = (rx_byte == next_byte(last_byte));
            byte_done   = (bit_cnt == 3'd7);
            bit_cnt_nxt = bit_cnt + 3'd1;

            case (state)
                ST_SEARCH: begin
                    if (nbits_nxt == NBIT_W'(WIN_W) &&
                        win_nxt[BYTE_W-1:0] == next_byte(win_nxt[WIN_W-1:BYTE_W])) begin
                        last_nxt    = win_nxt[BYTE_W-1:0];
                        bit_cnt_nxt = '0;
                        good_nxt    = CNT_W'(1);
                        miss_nxt    = '0;
                        state_nxt   = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (byte_done) begin
                        if (seq_match) begin
                            good_nxt = good_cnt + CNT_W'(1);
                            last_nxt = rx_byte;
                            if (good_nxt >= CNT_W'(LOCK_COUNT)) begin
                                state_nxt      = ST_LOCKED;
                                byte_out_nxt   = rx_byte;
                                byte_valid_nxt = 1'b1;
                            end
                        end else begin
                            state_nxt = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (byte_done) begin
                        byte_out_nxt   = rx_byte;
                        byte_valid_nxt = 1'b1;
                        last_nxt       = rx_byte;
                        if (seq_match) begin
                            miss_nxt = '0;
                        end else begin
                            seq_err_nxt = 1'b1;
                            miss_nxt    = miss_cnt + CNT_W'(1);
                            if (miss_nxt >= CNT_W'(MISS_LIMIT)) begin
                                state_nxt = ST_SEARCH;
                            end
                        end
                    end
                end
                default: state_nxt = ST_SEARCH;
            endcase
        end

        if ((phase_err_nxt || seq_err_nxt) && err_count != '1) begin
            err_nxt = err_count + BYTE_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SEARCH;
            win        <= '0;
            nbits      <= '0;
            bit_cnt    <= '0;
            good_cnt   <= '0;
            miss_cnt   <= '0;
            last_byte  <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            locked     <= 1'b0;
            phase_err  <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            win        <= win_nxt;
            nbits      <= nbits_nxt;
            bit_cnt    <= bit_cnt_nxt;
            good_cnt   <= good_nxt;
            miss_cnt   <= miss_nxt;
            last_byte  <= last_nxt;
            byte_out   <= byte_out_nxt;
            byte_valid <= byte_valid_nxt;
            locked     <= (state_nxt == ST_LOCKED);
            phase_err  <= phase_err_nxt;
            seq_err    <= seq_err_nxt;
            err_count  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_heartbeat_rx.sv
// Self-checking bench for heartbeat_rx: a transmitter line queue drives the
// DUT while a sample-stream reference model predicts every output each cycle.
module tb_heartbeat_rx;

    localparam int LOCK_COUNT = 4;
    localparam int MISS_LIMIT = 2;
    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       signal_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       locked;
    logic       phase_err;
    logic       seq_err;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    heartbeat_rx #(.LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .locked     (locked),
        .phase_err  (phase_err),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    int tests;
    int fails;
    int cyc;

    // Reference model: line samples -> half-bit pairs -> bits -> framing
    int m_sq, m_sq_vld, m_have_first, m_first;
    int m_state, m_win, m_nbits, m_pos, m_good, m_miss, m_last;
    int m_out, m_valid, m_locked, m_perr, m_serr, m_err;

    // Observed statistics since the last clear_stats
    logic       line_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         gap_q[$];
    int n_perr, n_serr, n_falls, lock_cyc, last_valid_cyc, lock_at_perr, prev_locked;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_bit(input int b);
        int rx;
        m_win = ((m_win << 1) | b) & 'hFFFF;
        if (m_nbits < 16) m_nbits++;
        rx = m_win & 255;
        if (m_state == M_SEARCH) begin
            if (m_nbits >= 16 && rx == (((m_win >> 8) + 1) % 256)) begin
                m_last = rx; m_pos = 0; m_good = 1; m_miss = 0; m_state = M_VERIFY;
            end
        end else begin
            m_pos++;
            if (m_pos == 8) begin
                m_pos = 0;
                if (m_state == M_VERIFY) begin
                    if (rx == (m_last + 1) % 256) begin
                        m_good++;
                        m_last = rx;
                        if (m_good >= LOCK_COUNT) begin
                            m_state = M_LOCKED; m_out = rx; m_valid = 1;
                        end
                    end else begin
                        m_state = M_SEARCH;
                    end
                end else begin
                    m_out = rx; m_valid = 1;
                    if (rx == (m_last + 1) % 256) begin
                        m_miss = 0;
                    end else begin
                        m_serr = 1;
                        m_miss++;
                        if (m_miss >= MISS_LIMIT) m_state = M_SEARCH;
                    end
                    m_last = rx;
                end
            end
        end
    endtask

    task automatic model_sample(input int s);
        if (m_have_first == 0) begin
            m_first = s; m_have_first = 1;
        end else if (s != m_first) begin
            m_have_first = 0;
            model_bit(m_first);
        end else begin
            m_perr = 1; m_nbits = 0; m_pos = 0; m_state = M_SEARCH;
        end
    endtask

    // One clock edge of the model; v is the line value sampled at that edge
    task automatic model_edge(input logic r, input logic v);
        m_valid = 0; m_perr = 0; m_serr = 0;
        if (r) begin
            m_sq = 0; m_sq_vld = 0; m_have_first = 0; m_first = 0;
            m_state = M_SEARCH; m_win = 0; m_nbits = 0; m_pos = 0;
            m_good = 0; m_miss = 0; m_last = 0; m_out = 0; m_err = 0;
        end else begin
            if (m_sq_vld != 0) model_sample(m_sq);
            m_sq = int'(v);
            m_sq_vld = 1;
            if ((m_perr != 0 || m_serr != 0) && m_err < 255) m_err++;
        end
        m_locked = (m_state == M_LOCKED) ? 1 : 0;
    endtask

    task automatic clear_stats();
        got_q.delete(); gap_q.delete(); exp_q.delete();
        n_perr = 0; n_serr = 0; n_falls = 0;
        lock_cyc = -1; last_valid_cyc = -1; lock_at_perr = -1;
    endtask

    task automatic step(input logic v, input logic r);
        signal_in = v;
        rst = r;
        @(posedge clk);
        model_edge(r, v);
        #1;
        cyc++;
        check("byte_out",   32'(byte_out),   32'(m_out));
        check("byte_valid", 32'(byte_valid), 32'(m_valid));
        check("locked",     32'(locked),     32'(m_locked));
        check("phase_err",  32'(phase_err),  32'(m_perr));
        check("seq_err",    32'(seq_err),    32'(m_serr));
        check("err_count",  32'(err_count),  32'(m_err));
        check("valid_only_when_locked", 32'(byte_valid & ~locked), 32'd0);
        if (byte_valid === 1'b1) begin
            got_q.push_back(byte_out);
            if (last_valid_cyc >= 0) gap_q.push_back(cyc - last_valid_cyc);
            last_valid_cyc = cyc;
        end
        if (phase_err === 1'b1) begin
            n_perr++;
            if (lock_at_perr < 0) lock_at_perr = int'(locked);
        end
        if (seq_err === 1'b1) n_serr++;
        if (prev_locked == 1 && locked === 1'b0) n_falls++;
        if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
        prev_locked = int'(locked);
    endtask

    task automatic push_bit(input logic b);
        line_q.push_back(b);
        line_q.push_back(~b);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endtask

    // n counter bytes from start, plus two bits of the next so the last
    // byte's delayed byte_valid is observed
    task automatic push_stream(input logic [7:0] start, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = start + 8'(i);
            push_byte(b);
        end
        b = start + 8'(n);
        push_bit(b[7]);
        push_bit(b[6]);
    endtask

    task automatic run_line();
        while (line_q.size() > 0) step(line_q.pop_front(), 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_byte_out"},   32'(byte_out),   32'd0);
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_locked"},     32'(locked),     32'd0);
        check({tag, "_phase_err"},  32'(phase_err),  32'd0);
        check({tag, "_seq_err"},    32'(seq_err),    32'd0);
        check({tag, "_err_count"},  32'(err_count),  32'd0);
    endtask

    task automatic do_reset();
        line_q.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check_zero_outputs("reset");
    endtask

    task automatic check_got(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_byte"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    initial begin
        logic [7:0] r8;
        logic       pad;
        int         raw;
        tests = 0; fails = 0; cyc = 0; prev_locked = 0;
        rst = 1'b1; signal_in = 1'b0;

        // In-phase stream from 0x10: lock, then bytes 0x14 onward
        do_reset();
        clear_stats();
        raw = cyc;
        push_stream(8'h10, 14);
        run_line();
        check("s1_lock_time", 32'((lock_cyc >= 0) && (lock_cyc - raw <= (LOCK_COUNT + 3) * 16 + 2)), 32'd1);
        for (int i = 0; i < 14 - LOCK_COUNT; i++) exp_q.push_back(8'h10 + 8'(LOCK_COUNT + i));
        check_got("s1");

        // One-clock offset: a single slip, then lock; err_count = phase errors
        do_reset();
        clear_stats();
        pad = 1'($urandom_range(0, 1));
        line_q.push_back(pad);
        push_stream(8'h10, 14);
        run_line();
        check("s2_phase_err_pulses", 32'(n_perr), 32'd1);
        check("s2_err_count", 32'(err_count), 32'(n_perr));
        check("s2_locked", 32'(locked), 32'd1);

        // 0x42 replaced by 0x50 while locked
        do_reset();
        clear_stats();
        for (int i = 0; i < 8; i++) push_byte(8'h3A + 8'(i));
        push_stream(8'h50, 7);
        run_line();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h3E + 8'(i));
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h50 + 8'(i));
        check_got("s3");
        check("s3_seq_err_pulses", 32'(n_serr), 32'd1);
        check("s3_lock_drops", 32'(n_falls), 32'd0);
        check("s3_locked", 32'(locked), 32'd1);

        // Counter wrap while locked
        do_reset();
        clear_stats();
        push_stream(8'hF5, 15);
        run_line();
        for (int i = 0; i < 11; i++) exp_q.push_back(8'hF9 + 8'(i));
        check_got("s4");
        check("s4_seq_err_pulses", 32'(n_serr), 32'd0);
        check("s4_gap_count", 32'(gap_q.size()), 32'd10);
        for (int i = 0; i < gap_q.size(); i++) check("s4_gap", 32'(gap_q[i]), 32'd16);

        // Forced half-bit violation while locked, then resync
        do_reset();
        r8 = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) push_byte(r8 + 8'(i));
        run_line();
        check("s5_locked_before", 32'(locked), 32'd1);
        clear_stats();
        r8 = r8 + 8'd8;
        for (int i = 7; i >= 4; i--) push_bit(r8[i]);
        line_q.push_back(1'b1);
        line_q.push_back(1'b1);
        for (int i = 2; i >= 0; i--) push_bit(r8[i]);
        push_stream(r8 + 8'd1, 16);
        run_line();
        check("s5_phase_err_seen", 32'(n_perr >= 1), 32'd1);
        check("s5_locked_at_phase_err", 32'(lock_at_perr), 32'd0);
        check("s5_relocked", 32'(locked), 32'd1);

        // Reset mid-byte while locked
        do_reset();
        r8 = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) push_byte(r8 + 8'(i));
        run_line();
        check("s6_locked_before", 32'(locked), 32'd1);
        push_stream(r8 + 8'd8, 17);
        for (int i = 0; i < 10; i++) step(line_q.pop_front(), 1'b0);
        step(line_q.pop_front(), 1'b1);
        check_zero_outputs("s6_midreset");
        clear_stats();
        run_line();
        check("s6_relocked", 32'(locked), 32'd1);

        // Random line noise: saturating error count, then recovery
        do_reset();
        clear_stats();
        for (int i = 0; i < 1200; i++) step(1'($urandom_range(0, 1)), 1'b0);
        raw = n_perr + n_serr;
        check("s7_err_count_sat", 32'(err_count), (raw > 255) ? 32'd255 : 32'(raw));
        push_stream(8'($urandom_range(0, 255)), 16);
        run_line();
        check("s7_relocked", 32'(locked), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
